// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection and stall control for a 5-stage core.
// Detects register read-after-write hazards that forwarding cannot cover
// (Tuse/Tnew comparison) and multiply/divide unit occupancy, and produces the
// PC/D enables and E flush that realise a stall.
// Optional feature: define HAZARD_STALL_CNT_EN to add a 32-bit stall-cycle
// counter exposed on the stallCount port.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rsAddr,
  input  logic [4:0]  D_rtAddr,
  input  logic [1:0]  D_TuseRs,
  input  logic [1:0]  D_TuseRt,
  input  logic        D_isMD,
  input  logic [4:0]  E_wAddr,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_wAddr,
  input  logic [1:0]  M_Tnew,
  input  logic        E_mdStart,
  input  logic        E_mdIsDiv,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        stall,
  output logic        mdBusy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stallCount
`endif
);

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  logic [3:0] md_cnt_q;
  logic [3:0] md_cnt_d;
  logic       md_busy_raw;
  logic       rs_stall;
  logic       rt_stall;

  // Next busy count: a new start always reloads (never accumulates), else count down to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_mdStart) begin
      md_cnt_d = E_mdIsDiv ? DIV_CYCLES : MUL_CYCLES;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // Busy counter register; reset aborts any countdown in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // Stall decision: a source stalls when its producer is ready later than it is needed.
  // Register 0 never stalls. Outputs are held inactive while reset is asserted.
  always_comb begin
    md_busy_raw = E_mdStart | (md_cnt_q != 4'd0);

    rs_stall = (D_rsAddr != 5'd0) &&
               (((E_wAddr == D_rsAddr) && (D_TuseRs < E_Tnew)) ||
                ((M_wAddr == D_rsAddr) && (D_TuseRs < M_Tnew)));

    rt_stall = (D_rtAddr != 5'd0) &&
               (((E_wAddr == D_rtAddr) && (D_TuseRt < E_Tnew)) ||
                ((M_wAddr == D_rtAddr) && (D_TuseRt < M_Tnew)));

    mdBusy = ~reset & md_busy_raw;
    stall  = ~reset & (rs_stall | rt_stall | (D_isMD & md_busy_raw));
    PC_en  = ~stall;
    D_en   = ~stall;
    E_clr  = stall;
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Next stall count: one per stalled cycle, wrapping silently.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the stall rules.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rsAddr, D_rtAddr, E_wAddr, M_wAddr;
  logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic        D_isMD, E_mdStart, E_mdIsDiv;
  logic        PC_en, D_en, E_clr, stall, mdBusy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallCount;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: cycles of multiply/divide occupancy left after this one, and stall total.
  int          busy_left = 0;
  int unsigned exp_cnt = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rsAddr(D_rsAddr), .D_rtAddr(D_rtAddr),
    .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_isMD(D_isMD),
    .E_wAddr(E_wAddr), .E_Tnew(E_Tnew), .M_wAddr(M_wAddr), .M_Tnew(M_Tnew),
    .E_mdStart(E_mdStart), .E_mdIsDiv(E_mdIsDiv),
    .PC_en(PC_en), .D_en(D_en), .E_clr(E_clr), .stall(stall), .mdBusy(mdBusy)
`ifdef HAZARD_STALL_CNT_EN
    , .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  // A source must wait if some in-flight producer of that register delivers later than needed.
  function automatic bit src_waits(input int r, input int tuse);
    int e_ready;
    int m_ready;
    e_ready = int'(E_Tnew);
    m_ready = int'(M_Tnew);
    if (r == 0) return 1'b0;
    if (r == int'(E_wAddr) && e_ready > tuse) return 1'b1;
    if (r == int'(M_wAddr) && m_ready > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    if (reset) return 1'b0;
    return E_mdStart || (busy_left > 0);
  endfunction

  function automatic bit model_stall();
    if (reset) return 1'b0;
    return src_waits(int'(D_rsAddr), int'(D_TuseRs)) ||
           src_waits(int'(D_rtAddr), int'(D_TuseRt)) ||
           (D_isMD && model_busy());
  endfunction

  task automatic idle_inputs();
    reset = 1'b0;
    D_rsAddr = 5'd0; D_rtAddr = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3;
    D_isMD = 1'b0; E_wAddr = 5'd0; E_Tnew = 2'd0; M_wAddr = 5'd0; M_Tnew = 2'd0;
    E_mdStart = 1'b0; E_mdIsDiv = 1'b0;
  endtask

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    if (!reset && model_stall()) exp_cnt = exp_cnt + 1;
    if (reset) begin
      busy_left = 0;
      exp_cnt = 0;
    end else if (E_mdStart) begin
      busy_left = E_mdIsDiv ? 10 : 5;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // Hazard, start and MD all active while reset: outputs must be neutral.
    idle_inputs();
    reset = 1'b1;
    D_rsAddr = 5'd8; D_TuseRs = 2'd0; E_wAddr = 5'd8; E_Tnew = 2'd2;
    E_mdStart = 1'b1; E_mdIsDiv = 1'b1; D_isMD = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b0 || PC_en !== 1'b1 || D_en !== 1'b1 || E_clr !== 1'b0 || mdBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b pc=%b d=%b clr=%b busy=%b want 0 1 1 0 0",
               stall, PC_en, D_en, E_clr, mdBusy);
    end
    tick();
    idle_inputs();
    D_isMD = 1'b1;
    #2;
    checks++;
    if (mdBusy !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mdcnt_zero got busy=%b stall=%b want 0 0", mdBusy, stall);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (stallCount !== 32'd0) begin
      failures++;
      $display("FAIL reset_stallcount got %0d want 0", stallCount);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    E_wAddr = 5'd8; E_Tnew = 2'd2; D_rsAddr = 5'd8; D_TuseRs = 2'd1; M_wAddr = 5'd0;
    #2;
    checks++;
    if (stall !== 1'b1 || PC_en !== 1'b0 || D_en !== 1'b0 || E_clr !== 1'b1) begin
      failures++;
      $display("FAIL load_use got stall=%b pc=%b d=%b clr=%b want 1 0 0 1", stall, PC_en, D_en, E_clr);
    end
    tick();
    E_wAddr = 5'd0;
    #2;
    checks++;
    if (stall !== 1'b0 || PC_en !== 1'b1) begin
      failures++;
      $display("FAIL load_use_release got stall=%b pc=%b want 0 1", stall, PC_en);
    end
    // Same hazard from M stage on rt.
    M_wAddr = 5'd17; M_Tnew = 2'd1; D_rtAddr = 5'd17; D_TuseRt = 2'd0;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL m_stage_rt got stall=%b want 1", stall);
    end
    tick();
  endtask

  task automatic test_forwardable();
    do_reset();
    E_wAddr = 5'd9; E_Tnew = 2'd1; D_rtAddr = 5'd9; D_TuseRt = 2'd1;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL forwardable got stall=%b want 0", stall);
    end
    tick();
    D_rtAddr = 5'd0; E_wAddr = 5'd0; E_Tnew = 2'd2; D_TuseRt = 2'd0;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reg0_rt got stall=%b want 0", stall);
    end
    // Register 0 on rs with both producers late.
    D_rsAddr = 5'd0; D_TuseRs = 2'd0; M_wAddr = 5'd0; M_Tnew = 2'd3; E_Tnew = 2'd3;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reg0_rs got stall=%b want 0", stall);
    end
    // Unsigned boundary: Tuse=3 (unused) never below Tnew=3.
    D_rsAddr = 5'd31; D_TuseRs = 2'd3; E_wAddr = 5'd31; E_Tnew = 2'd3;
    #2;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL tuse3_tnew3 got stall=%b want 0", stall);
    end
    D_TuseRs = 2'd2;
    #2;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL tuse2_tnew3 got stall=%b want 1", stall);
    end
    tick();
  endtask

  task automatic test_multiply();
    do_reset();
    D_isMD = 1'b1;
    for (int c = 0; c < 8; c++) begin
      E_mdStart = (c == 0);
      E_mdIsDiv = 1'b0;
      #2;
      checks++;
      if (mdBusy !== (c <= 5) || stall !== (c <= 5)) begin
        failures++;
        $display("FAIL mult_cycle%0d got busy=%b stall=%b want %b", c, mdBusy, stall, (c <= 5));
      end
      tick();
    end
    // Busy unit does not stall a non-MD instruction.
    E_mdStart = 1'b1; D_isMD = 1'b0;
    #2;
    checks++;
    if (mdBusy !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL non_md_no_stall got busy=%b stall=%b want 1 0", mdBusy, stall);
    end
    tick();
    E_mdStart = 1'b0;
    tick();
  endtask

  task automatic test_divide_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      E_mdStart = (c == 0);
      E_mdIsDiv = 1'b1;
      reset = (c == 3);
      D_isMD = (c == 4);
      #2;
      if (c == 3) begin
        checks++;
        if (mdBusy !== 1'b0) begin
          failures++;
          $display("FAIL div_reset_busy got %b want 0", mdBusy);
        end
      end
      if (c == 4) begin
        checks++;
        if (stall !== 1'b0 || mdBusy !== 1'b0) begin
          failures++;
          $display("FAIL div_after_reset got stall=%b busy=%b want 0 0", stall, mdBusy);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    // A mult then a divide started mid-countdown: the divide reloads, no accumulation.
    do_reset();
    D_isMD = 1'b1;
    for (int c = 0; c < 16; c++) begin
      E_mdStart = (c == 0) || (c == 3);
      E_mdIsDiv = (c == 3);
      #2;
      checks++;
      if (mdBusy !== (c <= 13)) begin
        failures++;
        $display("FAIL reload_cycle%0d got busy=%b want %b", c, mdBusy, (c <= 13));
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit eb;
    bit es;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 39) == 0);
      D_rsAddr  = 5'($urandom_range(0, 3));
      D_rtAddr  = 5'($urandom_range(0, 3));
      D_TuseRs  = 2'($urandom_range(0, 3));
      D_TuseRt  = 2'($urandom_range(0, 3));
      D_isMD    = 1'($urandom_range(0, 1));
      E_wAddr   = 5'($urandom_range(0, 3));
      E_Tnew    = 2'($urandom_range(0, 3));
      M_wAddr   = 5'($urandom_range(0, 3));
      M_Tnew    = 2'($urandom_range(0, 3));
      E_mdStart = ($urandom_range(0, 9) == 0);
      E_mdIsDiv = 1'($urandom_range(0, 1));
      #2;
      eb = model_busy();
      es = model_stall();
      checks++;
      if (stall !== es || PC_en !== !es || D_en !== !es || E_clr !== es || mdBusy !== eb) begin
        failures++;
        $display("FAIL random_c%0d got stall=%b pc=%b d=%b clr=%b busy=%b want stall=%b busy=%b",
                 c, stall, PC_en, D_en, E_clr, mdBusy, es, eb);
      end
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      if (stallCount !== exp_cnt) begin
        failures++;
        $display("FAIL random_cnt_c%0d got %0d want %0d", c, stallCount, exp_cnt);
      end
`endif
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_counter();
    do_reset();
    E_wAddr = 5'd8; E_Tnew = 2'd2; D_rsAddr = 5'd8; D_TuseRs = 2'd1;
    for (int c = 0; c < 7; c++) tick();
    idle_inputs();
    #2;
    checks++;
    if (stallCount !== 32'd7 || stallCount !== exp_cnt) begin
      failures++;
      $display("FAIL count7 got %0d want 7", stallCount);
    end
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    E_wAddr = 5'd8; E_Tnew = 2'd2; D_rsAddr = 5'd8; D_TuseRs = 2'd1;
    tick();
    idle_inputs();
    #2;
    checks++;
    if (stallCount !== 32'd0) begin
      failures++;
      $display("FAIL count_wrap got %0h want 0", stallCount);
    end
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_forwardable();
    test_multiply();
    test_divide_reset();
    test_back_to_back();
    test_random();
`ifdef HAZARD_STALL_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide ports, one per line, in this order (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- D_rsAddr  in  5  rs index of the instruction in D
- D_rtAddr  in  5  rt index of the instruction in D
- D_TuseRs  in  2  cycles until D needs rs (0..2; 3 = not used)
- D_TuseRt  in  2  cycles until D needs rt (0..2; 3 = not used)
- D_isMD  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_wAddr  in  5  destination register of the instruction in E (0 = none)
- E_Tnew  in  2  cycles until E's result is forwardable
- M_wAddr  in  5  destination register of the instruction in M (0 = none)
- M_Tnew  in  2  cycles until M's result is forwardable
- E_mdStart  in  1  E holds mult/multu/div/divu this cycle
- E_mdIsDiv  in  1  qualifies E_mdStart: 1 = div/divu, 0 = mult/multu
- PC_en  out  1  PC write enable
- D_en  out  1  D pipeline register enable
- E_clr  out  1  E pipeline register flush (drives E register reset input)
- stall  out  1  pipeline stall indicator
- mdBusy  out  1  multiply/divide unit busy
- stallCount  out  32  stall-cycle counter (present only with STALL_CNT_EN)
REQ-002 SHALL use one clock, clk; reset SHALL be synchronous and active-high, sampled on posedge clk.

Function
REQ-003 SHALL hold a 4-bit busy counter mdCnt, updated on posedge clk in priority order: reset -> 0; else E_mdStart -> (E_mdIsDiv ? 10 : 5); else mdCnt != 0 -> mdCnt - 1; else hold.
REQ-004 SHALL reload mdCnt when E_mdStart coincides with nonzero mdCnt; it SHALL NOT accumulate.
REQ-005 SHALL drive mdBusy = E_mdStart | (mdCnt != 0), combinationally.
REQ-006 SHALL assert rsStall when D_rsAddr != 0 and either (E_wAddr == D_rsAddr and D_TuseRs < E_Tnew) or (M_wAddr == D_rsAddr and D_TuseRs < M_Tnew).
REQ-007 SHALL assert rtStall by the same rule using D_rtAddr and D_TuseRt.
REQ-008 SHALL drive stall = rsStall | rtStall | (D_isMD & mdBusy), combinationally, with zero-cycle latency.
REQ-009 SHALL drive PC_en = D_en = ~stall and E_clr = stall.
REQ-010 SHALL compare Tuse and Tnew as unsigned 2-bit values.
REQ-011 SHALL never stall on register 0, whatever the Tnew values.
REQ-012 SHALL perform no stall decision based on mdCnt for instructions with D_isMD = 0.

Reset
REQ-013 While reset = 1, SHALL force stall = 0, PC_en = 1, D_en = 1, E_clr = 0 and mdBusy = 0.
REQ-014 After any posedge clk with reset = 1, mdCnt SHALL be 0 and stallCount SHALL be 0.
REQ-015 Reset asserted mid-multiply/divide SHALL abort the busy countdown immediately.

Configuration
REQ-016 With macro HAZARD_STALL_CNT_EN defined, SHALL include the stallCount port and a 32-bit register that increments by 1 on every posedge clk where reset = 0 and stall = 1.
REQ-017 stallCount SHALL wrap from 0xFFFFFFFF to 0 without any flag.
REQ-018 Without HAZARD_STALL_CNT_EN, the stallCount port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-019 Load-use: E_wAddr=8, E_Tnew=2, D_rsAddr=8, D_TuseRs=1, M_wAddr=0 -> stall=1, PC_en=0, D_en=0, E_clr=1 in the same cycle; with E_wAddr=0 next cycle -> stall=0.
REQ-020 Forwardable: E_wAddr=9, E_Tnew=1, D_rtAddr=9, D_TuseRt=1 -> stall=0; with D_rtAddr=0, E_wAddr=0, E_Tnew=2, D_TuseRt=0 -> stall=0.
REQ-021 Multiply: E_mdStart=1, E_mdIsDiv=0 for one cycle (cycle 0), D_isMD=1 held -> mdBusy=1 and stall=1 for cycles 0..5, and 0 from cycle 6.
REQ-022 Divide then reset: E_mdStart=1, E_mdIsDiv=1 at cycle 0, reset=1 at cycle 3 -> mdBusy=0 during cycle 3; with D_isMD=1 at cycle 4 -> stall=0.
REQ-023 Counter (HAZARD_STALL_CNT_EN): 7 stall cycles after reset -> stallCount=7; force counter to 0xFFFFFFFF, then 1 stall cycle -> stallCount=0.
